// File: rtl/player_jump.sv
// player_jump: a SIZE x SIZE cube that walks left/right and jumps. Motion
//   and state change once per frame_tick. The cube's colour is drawn at the
//   scan position.
// Latency: pos_x/pos_y/airborne come straight from registers and update in
//   the frame_tick clk. color has one clk of latency from pix_x/pix_y/pix_v.
// Backpressure: none. A jump edge seen between ticks is held pending until
//   the next frame_tick consumes it.
// Ports: clk/rst (async active-low), pix_x/pix_y/pix_v scan position,
//   frame_tick, jump/left/right controls, box_color {b,g,r} in;
//   color[2:0] {b,g,r}, pos_x/pos_y top-left, airborne out.
// Option: define PLAYER_DOUBLE_JUMP_EN to allow one extra jump in the air.
module player_jump #(
   parameter int pA      = 10,
   parameter int cA      = 4,
   parameter int SIZE    = 20,
   parameter int H_RES   = 640,
   parameter int X_INIT  = 300,
   parameter int FLOOR_Y = 400,
   parameter int X_SPEED = 2,
   parameter int JUMP_V  = 12,
   parameter int GRAV    = 1,
   parameter int VMAX    = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [pA-1:0]        pix_x,
   input  logic [pA-1:0]        pix_y,
   input  logic                 pix_v,
   input  logic                 frame_tick,
   input  logic                 jump,
   input  logic                 left,
   input  logic                 right,
   input  logic [3*cA-1:0]      box_color,
   output logic [2:0][cA-1:0]   color,
   output logic [pA-1:0]        pos_x,
   output logic [pA-1:0]        pos_y,
   output logic                 airborne
);

   // One extra bit keeps signed intermediate results from wrapping.
   localparam int SW = pA + 1;

   localparam logic signed [SW-1:0] C_ZERO  = '0;
   localparam logic signed [SW-1:0] C_XINIT = SW'(X_INIT);
   localparam logic signed [SW-1:0] C_XMAX  = SW'(H_RES - SIZE);
   localparam logic signed [SW-1:0] C_XSPD  = SW'(X_SPEED);
   localparam logic signed [SW-1:0] C_FLOOR = SW'(FLOOR_Y);
   localparam logic signed [SW-1:0] C_JUMPV = SW'(JUMP_V);
   localparam logic signed [SW-1:0] C_GRAV  = SW'(GRAV);
   localparam logic signed [SW-1:0] C_VMAX  = SW'(VMAX);
   localparam logic        [SW-1:0] C_SZM1  = SW'(SIZE - 1);

   typedef enum logic [1:0] {GROUND = 2'd0, RISE = 2'd1, FALL = 2'd2} state_t;

   state_t                 state_q, state_d;
   logic signed [SW-1:0]   x_q, x_d, y_q, y_d, vy_q, vy_d;
   logic                   jump_q, pend_q, pend_d, air_q;
   logic [2:0][cA-1:0]     color_q, color_d;

   logic                   jump_now, dj_go, hit;
   logic signed [SW-1:0]   x_step, y_up, y_dn, vy_dec, vy_inc;
   logic        [SW-1:0]   px, py, xu, yu;

   // An edge arriving in the tick clk itself counts for that tick.
   assign jump_now = pend_q | (jump & ~jump_q);

`ifdef PLAYER_DOUBLE_JUMP_EN
   logic used_q, used_d;
   assign dj_go = jump_now & ~used_q;
`else
   assign dj_go = 1'b0;
`endif

   // Horizontal candidate: opposing inputs cancel, then clamp to the screen.
   always_comb begin
      x_step = x_q;
      if (right && !left)      x_step = x_q + C_XSPD;
      else if (left && !right) x_step = x_q - C_XSPD;
      if (x_step < C_ZERO)      x_step = C_ZERO;
      else if (x_step > C_XMAX) x_step = C_XMAX;
   end

   assign vy_dec = vy_q - C_GRAV;
   assign vy_inc = ((vy_q + C_GRAV) > C_VMAX) ? C_VMAX : (vy_q + C_GRAV);
   assign y_up   = y_q - vy_q;
   assign y_dn   = y_q + vy_inc;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      vy_d    = vy_q;
      pend_d  = jump_now;
`ifdef PLAYER_DOUBLE_JUMP_EN
      used_d  = used_q;
`endif
      if (frame_tick) begin
         pend_d = 1'b0;   // consumed whether or not it is honoured
         x_d    = x_step;
         case (state_q)
            GROUND: begin
               if (jump_now) begin
                  vy_d    = C_JUMPV;
                  state_d = RISE;
               end
            end
            RISE, FALL: begin
               if (dj_go) begin
                  // Mid-air relaunch: speed restarts, height held this tick.
                  vy_d    = C_JUMPV;
                  state_d = RISE;
`ifdef PLAYER_DOUBLE_JUMP_EN
                  used_d  = 1'b1;
`endif
               end else if (state_q == RISE) begin
                  y_d = (y_up < C_ZERO) ? C_ZERO : y_up;
                  if (vy_dec <= C_ZERO) begin
                     vy_d    = C_ZERO;
                     state_d = FALL;
                  end else begin
                     vy_d = vy_dec;
                  end
               end else begin
                  if (y_dn >= C_FLOOR) begin
                     y_d     = C_FLOOR;
                     vy_d    = C_ZERO;
                     state_d = GROUND;
`ifdef PLAYER_DOUBLE_JUMP_EN
                     used_d  = 1'b0;
`endif
                  end else begin
                     y_d  = y_dn;
                     vy_d = vy_inc;
                  end
               end
            end
            default: state_d = GROUND;
         endcase
      end
   end

   // Position is never negative, so the unsigned view is exact.
   assign px = {1'b0, pix_x};
   assign py = {1'b0, pix_y};
   assign xu = x_q;
   assign yu = y_q;
   assign hit = pix_v && (px >= xu) && (px <= xu + C_SZM1)
                      && (py >= yu) && (py <= yu + C_SZM1);
   assign color_d = hit ? box_color : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= GROUND;
         x_q     <= C_XINIT;
         y_q     <= C_FLOOR;
         vy_q    <= C_ZERO;
         jump_q  <= 1'b0;
         pend_q  <= 1'b0;
         air_q   <= 1'b0;
         color_q <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         vy_q    <= vy_d;
         jump_q  <= jump;
         pend_q  <= pend_d;
         air_q   <= (state_d != GROUND);
         color_q <= color_d;
      end
   end

`ifdef PLAYER_DOUBLE_JUMP_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) used_q <= 1'b0;
      else      used_q <= used_d;
   end
`endif

   assign pos_x    = x_q[pA-1:0];
   assign pos_y    = y_q[pA-1:0];
   assign airborne = air_q;
   assign color    = color_q;

endmodule

// File: doc/player_jump.md
PLAYER_JUMP -- requirements
Module: player_jump

Interface
REQ-001 SHALL have parameter pA, default 10, pixel-coordinate and position width.
REQ-002 SHALL have parameter cA, default 4, per-channel colour width.
REQ-003 SHALL have parameters SIZE 20 (cube edge, px), H_RES 640 (visible width), X_INIT 300 (reset x), FLOOR_Y 400 (ground-level top y), X_SPEED 2 (px/tick), JUMP_V 12 (launch speed), GRAV 1 (speed change/tick), VMAX 12 (fall speed cap).
REQ-004 SHALL have ports: clk input 1, system clock; rst input 1, asynchronous active-low reset.
REQ-005 SHALL have ports: pix_x input pA, pix_y input pA, scan position; pix_v input 1, visible-pixel flag.
REQ-006 SHALL have ports: frame_tick input 1, one-clk pulse once per frame; jump input 1, level, active-high; left/right input 1 each, active-high.
REQ-007 SHALL have port box_color input 3*cA, packed {blue,green,red}.
REQ-008 SHALL have ports: color output cA [2:0] (2=blue,1=green,0=red); pos_x/pos_y output pA, cube top-left; airborne output 1.

Function
REQ-009 SHALL implement FSM GROUND, RISE, FALL; airborne = (state != GROUND).
REQ-010 SHALL register jump, detect its rising edge, and hold a pending-jump flag until the next frame_tick, which consumes it; an edge in the same clk as frame_tick counts for that tick.
REQ-011 SHALL update position and state only in clks where frame_tick=1.
REQ-012 GROUND + pending jump: vy<=JUMP_V, state<=RISE, y unchanged that tick.
REQ-013 RISE: y<=y-vy, vy<=vy-GRAV; if vy-GRAV<=0 then vy<=0 and state<=FALL.
REQ-014 FALL: v'=min(vy+GRAV,VMAX); if y+v'>=FLOOR_Y then y<=FLOOR_Y, vy<=0, state<=GROUND, else y<=y+v', vy<=v'.
REQ-015 Horizontal, each tick: right only -> x+X_SPEED, left only -> x-X_SPEED, both or neither -> hold; result clamped to [0, H_RES-SIZE].
REQ-016 Vertical arithmetic SHALL use signed pA+1 bits, no wrap; y never exceeds FLOOR_Y or goes below 0 (clamp to 0).
REQ-017 Hit = pix_v && x<=pix_x<=x+SIZE-1 && y<=pix_y<=y+SIZE-1 (inclusive, exactly SIZE px square).
REQ-018 color SHALL be registered: one clk latency from pix_x/pix_y/pix_v; hit -> box_color channels, else 0.
REQ-019 pos_x, pos_y, airborne SHALL be direct register outputs.

Reset
REQ-020 On rst=0, asynchronously: x=X_INIT, y=FLOOR_Y, vy=0, state=GROUND, pending=0, jump history=0, color all 0, double-jump-used=0.
REQ-021 Reset mid-jump SHALL abandon the jump; first frame_tick after release acts from GROUND.

Configuration
REQ-022 Macro PLAYER_DOUBLE_JUMP_EN defined: in RISE or FALL with pending jump and used=0, tick sets vy<=JUMP_V, state<=RISE, used<=1, no y move that tick; used clears on landing.
REQ-023 Macro undefined: pending jumps in RISE/FALL SHALL be consumed and ignored; no used flag implemented.

Verification
REQ-024 Reset, no input, 5 ticks -> pos_x=300, pos_y=400, airborne=0, color=0.
REQ-025 Jump edge then ticks -> RISE; after 12 motion ticks pos_y=322, FALL; after 12 more pos_y=400, airborne=0 (25 ticks total incl. launch).
REQ-026 right held 200 ticks -> pos_x stops at 620; left held 400 ticks -> stops at 0; both held -> unchanged.
REQ-027 box_color=12'hF0A, cube at (300,400): pix (300,400) and (319,419) with pix_v=1 -> color {F,0,A} one clk later; (320,400), (300,420), or pix_v=0 -> 0.
REQ-028 Jump edge at tick 5 of RISE -> with PLAYER_DOUBLE_JUMP_EN vy restarts at 12, airborne longer; third edge ignored; without macro trajectory equals REQ-025.
REQ-029 rst low while pos_y=340 -> pos_y=400, state GROUND immediately, color 0, before next clk edge.
